safe_lock_fsm: RTL
==================

Name: safe_lock_fsm

Overview:
- Combination-lock core directly upstream of the chip's output pin mapping in tt_um_entropicentity_Safe_ASIC.
- Consumes debounced keypad digit strobes from ui_in and produces the unlocked, lockout and status flags driven onto uo_out.
- Holds a reprogrammable code, counts failed attempts and enforces a timed lockout.

Parameters:
- CODE_LEN, 4, number of decimal digits per code (1..8).
- DEFAULT_CODE, 32'h0000_1234, reset code as packed BCD nibbles; the low CODE_LEN nibbles are used, and the first digit entered is the most significant used nibble.
- MAX_FAILS, 3, consecutive mismatches that trigger lockout (1..15).
- LOCKOUT_CYCLES, 1024, lockout duration in clk cycles (>=2).
- RELOCK_CYCLES, 4096, inactivity timeout for the optional auto-relock feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- digit_valid  in  1  one-cycle strobe: digit is valid
- digit  in  4  0-9 = decimal digit; 4'hF = clear entry; 4'hA-4'hE = ignored
- lock_cmd  in  1  re-lock request (level, sampled each cycle)
- prog_cmd  in  1  enter programming mode (only honoured while UNLOCKED)
- unlocked  out  1  high in UNLOCKED and PROGRAM
- lockout  out  1  high in LOCKOUT
- programming  out  1  high in PROGRAM
- ok_pulse  out  1  one-cycle pulse on a code match or on program completion
- fail_pulse  out  1  one-cycle pulse on a mismatch
- digit_count  out  4  digits buffered in the current entry
- fail_count  out  4  consecutive failures so far

Behaviour:
- Reset applies when rst_n is low at a clk edge.
  - State = LOCKED; code = DEFAULT_CODE; entry buffer, digit_count, fail_count and timers = 0.
  - All outputs = 0.
  - Reset mid-entry or mid-lockout discards all progress, and any programmed code reverts to DEFAULT_CODE.
- States are LOCKED, UNLOCKED, PROGRAM and LOCKOUT. All outputs are registered.
- LOCKED:
  - A valid digit 0-9 shifts into the entry buffer and increments digit_count.
  - When the CODE_LEN-th digit is accepted, it is compared with the stored code in the same cycle. On the next edge digit_count returns to 0 and one of these happens:
    - Match: go to UNLOCKED, pulse ok_pulse, clear fail_count. unlocked rises one cycle after the final digit strobe.
    - Mismatch: pulse fail_pulse and increment fail_count. If the new fail_count equals MAX_FAILS, go to LOCKOUT; otherwise stay in LOCKED.
  - Digit 4'hF clears the entry buffer and digit_count to 0. It does not count as a failure.
  - Digits 4'hA-4'hE are ignored.
  - lock_cmd clears the entry buffer (state unchanged). prog_cmd is ignored.
- LOCKOUT:
  - A timer counts LOCKOUT_CYCLES cycles from entry.
  - All digits and commands are ignored.
  - On expiry, go to LOCKED with fail_count = 0.
- UNLOCKED:
  - Digits are ignored.
  - lock_cmd: go to LOCKED.
  - prog_cmd (with lock_cmd low): go to PROGRAM with digit_count = 0.
- PROGRAM:
  - Digits 0-9 are collected exactly as in LOCKED. 4'hF restarts the entry.
  - After CODE_LEN digits, the stored code is replaced, ok_pulse fires and the state returns to UNLOCKED.
  - lock_cmd aborts: the stored code is unchanged and the state goes to LOCKED.
- Priority in any cycle: reset > lock_cmd > prog_cmd > digit_valid. A digit arriving in the same cycle as an honoured command is dropped.
- ok_pulse and fail_pulse are never high together, and each lasts exactly one cycle.
- Counter rules:
  - digit_count never exceeds CODE_LEN.
  - fail_count saturates at MAX_FAILS.
  - The timers are sized with $clog2 of their terminal count, with no wrap-around aliasing.

Optional Feature:
- Macro: SAFE_AUTO_RELOCK_EN.
- Defined:
  - In UNLOCKED, an inactivity counter increments every cycle. Any digit_valid or prog_cmd resets it.
  - When it reaches RELOCK_CYCLES, the state goes to LOCKED. No pulse is generated.
  - PROGRAM is not subject to the timeout.
- Undefined: UNLOCKED persists until lock_cmd or reset, and the counter logic is absent.

Test Plan:
- Reset, then digits 1,2,3,4 -> unlocked=1 one cycle after the 4th strobe; ok_pulse high for 1 cycle; fail_count=0.
- Digits 1,2,3,5 three times -> fail_pulse three times, fail_count 1,2,3, then lockout=1. Digits 1,2,3,4 entered during lockout are ignored. lockout drops after exactly 1024 cycles, with fail_count=0.
- Digits 1,2,F,1,2,3,4 -> unlocked=1, no fail_pulse. Digit 4'hB mid-entry leaves digit_count unchanged.
- Unlock, prog_cmd, digits 9,8,7,6 -> ok_pulse, back in UNLOCKED. Then lock_cmd; 1,2,3,4 fails; 9,8,7,6 unlocks.
- In PROGRAM after 2 digits, lock_cmd together with digit_valid -> LOCKED; old code 1,2,3,4 still unlocks. In UNLOCKED, lock_cmd and prog_cmd together -> LOCKED. rst_n low mid-entry -> digit_count=0 and all outputs 0.
- With SAFE_AUTO_RELOCK_EN and RELOCK_CYCLES=16: unlock, then idle -> unlocked falls after 16 cycles. A digit strobe at cycle 10 extends unlocked to cycle 26.

Source files
------------

// File: rtl/safe_lock_fsm.sv
// safe_lock_fsm: combination-lock core with fail counting and timed lockout.
// Define SAFE_AUTO_RELOCK_EN to relock after RELOCK_CYCLES idle unlocked cycles.
module safe_lock_fsm #(
   parameter int          CODE_LEN       = 4,
   parameter logic [31:0] DEFAULT_CODE   = 32'h0000_1234,
   parameter int          MAX_FAILS      = 3,
   parameter int          LOCKOUT_CYCLES = 1024,
   parameter int          RELOCK_CYCLES  = 4096
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       digit_valid,
   input  logic [3:0] digit,
   input  logic       lock_cmd,
   input  logic       prog_cmd,
   output logic       unlocked,
   output logic       lockout,
   output logic       programming,
   output logic       ok_pulse,
   output logic       fail_pulse,
   output logic [3:0] digit_count,
   output logic [3:0] fail_count
);

   localparam int CW = 4 * CODE_LEN;
   localparam int LW = $clog2(LOCKOUT_CYCLES);

   if (CODE_LEN < 1 || CODE_LEN > 8 || MAX_FAILS < 1 || MAX_FAILS > 15 ||
       LOCKOUT_CYCLES < 2 || RELOCK_CYCLES < 2) begin : g_bad_cfg
      $error("safe_lock_fsm: parameter out of range");
   end

   typedef enum logic [1:0] {
      S_LOCKED,
      S_UNLOCKED,
      S_PROGRAM,
      S_LOCKOUT
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_code;
   logic [CW-1:0]   r_entry;
   logic [3:0]      r_dcnt;
   logic [3:0]      r_fcnt;
   logic [LW-1:0]   r_ltmr;
   logic            r_unlocked;
   logic            r_lockout;
   logic            r_prog;
   logic            r_ok;
   logic            r_fail;

   state_t          w_state_nx;
   logic [CW-1:0]   w_code_nx;
   logic [CW-1:0]   w_entry_nx;
   logic [3:0]      w_dcnt_nx;
   logic [3:0]      w_fcnt_nx;
   logic [LW-1:0]   w_ltmr_nx;
   logic            w_ok_nx;
   logic            w_fail_nx;
   logic [3:0]      w_fcnt_inc;

   logic            w_is_dig;
   logic            w_is_clr;
   logic            w_full;
   logic            w_match;
   logic [CW-1:0]   w_shift;

`ifdef SAFE_AUTO_RELOCK_EN
   localparam int RW = $clog2(RELOCK_CYCLES);
   logic [RW-1:0]   r_rtmr;
   logic [RW-1:0]   w_rtmr_nx;
`endif

   // First digit entered ends up in the most significant nibble.
   assign w_shift    = CW'({r_entry, digit});
   assign w_is_dig   = digit_valid && (digit <= 4'd9);
   assign w_is_clr   = digit_valid && (digit == 4'hF);
   assign w_full     = (r_dcnt == 4'(CODE_LEN - 1));
   assign w_match    = (w_shift == r_code);
   assign w_fcnt_inc = (r_fcnt == 4'(MAX_FAILS)) ? r_fcnt : r_fcnt + 4'd1;

   always_comb begin
      w_state_nx = r_state;
      w_code_nx  = r_code;
      w_entry_nx = r_entry;
      w_dcnt_nx  = r_dcnt;
      w_fcnt_nx  = r_fcnt;
      w_ltmr_nx  = r_ltmr;
      w_ok_nx    = 1'b0;
      w_fail_nx  = 1'b0;
`ifdef SAFE_AUTO_RELOCK_EN
      w_rtmr_nx  = '0;
`endif
      unique case (r_state)
         S_LOCKED: begin
            if (lock_cmd || w_is_clr) begin
               w_entry_nx = '0;
               w_dcnt_nx  = '0;
            end else if (w_is_dig) begin
               if (w_full) begin
                  w_entry_nx = '0;
                  w_dcnt_nx  = '0;
                  if (w_match) begin
                     w_state_nx = S_UNLOCKED;
                     w_ok_nx    = 1'b1;
                     w_fcnt_nx  = '0;
                  end else begin
                     w_fail_nx = 1'b1;
                     w_fcnt_nx = w_fcnt_inc;
                     if (w_fcnt_inc == 4'(MAX_FAILS)) begin
                        w_state_nx = S_LOCKOUT;
                        w_ltmr_nx  = '0;
                     end
                  end
               end else begin
                  w_entry_nx = w_shift;
                  w_dcnt_nx  = r_dcnt + 4'd1;
               end
            end
         end
         S_LOCKOUT: begin
            if (r_ltmr == LW'(LOCKOUT_CYCLES - 1)) begin
               w_state_nx = S_LOCKED;
               w_fcnt_nx  = '0;
               w_ltmr_nx  = '0;
            end else begin
               w_ltmr_nx = r_ltmr + 1'b1;
            end
         end
         S_UNLOCKED: begin
            if (lock_cmd) begin
               w_state_nx = S_LOCKED;
               w_entry_nx = '0;
               w_dcnt_nx  = '0;
            end else if (prog_cmd) begin
               w_state_nx = S_PROGRAM;
               w_entry_nx = '0;
               w_dcnt_nx  = '0;
            end
`ifdef SAFE_AUTO_RELOCK_EN
            else if (!digit_valid) begin
               if (r_rtmr == RW'(RELOCK_CYCLES - 1)) begin
                  w_state_nx = S_LOCKED;
               end else begin
                  w_rtmr_nx = r_rtmr + 1'b1;
               end
            end
`endif
         end
         S_PROGRAM: begin
            if (lock_cmd) begin
               w_state_nx = S_LOCKED;
               w_entry_nx = '0;
               w_dcnt_nx  = '0;
            end else if (w_is_clr) begin
               w_entry_nx = '0;
               w_dcnt_nx  = '0;
            end else if (w_is_dig) begin
               if (w_full) begin
                  w_code_nx  = w_shift;
                  w_state_nx = S_UNLOCKED;
                  w_ok_nx    = 1'b1;
                  w_entry_nx = '0;
                  w_dcnt_nx  = '0;
               end else begin
                  w_entry_nx = w_shift;
                  w_dcnt_nx  = r_dcnt + 4'd1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_LOCKED;
         r_code     <= CW'(DEFAULT_CODE);
         r_entry    <= '0;
         r_dcnt     <= '0;
         r_fcnt     <= '0;
         r_ltmr     <= '0;
         r_unlocked <= 1'b0;
         r_lockout  <= 1'b0;
         r_prog     <= 1'b0;
         r_ok       <= 1'b0;
         r_fail     <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_code     <= w_code_nx;
         r_entry    <= w_entry_nx;
         r_dcnt     <= w_dcnt_nx;
         r_fcnt     <= w_fcnt_nx;
         r_ltmr     <= w_ltmr_nx;
         r_unlocked <= (w_state_nx == S_UNLOCKED) || (w_state_nx == S_PROGRAM);
         r_lockout  <= (w_state_nx == S_LOCKOUT);
         r_prog     <= (w_state_nx == S_PROGRAM);
         r_ok       <= w_ok_nx;
         r_fail     <= w_fail_nx;
      end
   end

`ifdef SAFE_AUTO_RELOCK_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rtmr <= '0;
      end else begin
         r_rtmr <= w_rtmr_nx;
      end
   end
`endif

   assign unlocked    = r_unlocked;
   assign lockout     = r_lockout;
   assign programming = r_prog;
   assign ok_pulse    = r_ok;
   assign fail_pulse  = r_fail;
   assign digit_count = r_dcnt;
   assign fail_count  = r_fcnt;

endmodule
